hazard_stall_ctrl: RTL
======================

Name: hazard_stall_ctrl

Overview:
Sequential stall controller for the 5-stage MIPS pipeline. It detects load-use hazards in ID and sequences the multi-cycle multiply/divide unit (MULT/MULTU/DIV/DIVU). It holds HI/LO consumers and back-to-back MD issues until results retire. It produces the Stall signal consumed by the control unit, plus PC/IF-ID write enables and MD-unit start/done strobes.

Parameters:
MULT_CYCLES, 4, execute cycles for MULT/MULTU (≥1)
DIV_CYCLES, 32, execute cycles for DIV/DIVU (≥1)
CNT_W, 6, counter width; must hold max(MULT_CYCLES,DIV_CYCLES)-1

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  synchronous active-low reset
id_rs  input  5  rs field of instruction in ID
id_rt  input  5  rt field of instruction in ID
id_uses_rs  input  1  ID instruction reads rs
id_uses_rt  input  1  ID instruction reads rt
id_md_op  input  1  ID instruction is MULT/MULTU/DIV/DIVU
id_md_div  input  1  qualifies id_md_op: 1=divide, 0=multiply
id_reads_hilo  input  1  ID instruction is MFHI/MFLO
id_flush  input  1  ID instruction is being squashed (branch/jump redirect)
ex_rd  input  5  destination register of instruction in EX
ex_is_load  input  1  EX instruction is a load
Stall  output  1  pipeline stall to control unit
pc_we  output  1  PC register write enable
ifid_we  output  1  IF/ID register write enable
md_start  output  1  one-cycle start strobe to MD datapath
md_busy  output  1  MD operation in flight (BUSY or DONE)
md_done  output  1  one-cycle strobe; MD unit writes HI/LO at end of this cycle

Behaviour:
- Reset (rst_n=0 at rising edge): state=IDLE, cnt=0, md_done=0, md_busy=0. Combinational outputs then evaluate from IDLE.
- Reset mid-operation aborts any in-flight MD op. No md_done is issued for it.
- FSM states: IDLE, BUSY, DONE.
  - IDLE→BUSY on md_start; cnt loaded with (id_md_div ? DIV_CYCLES : MULT_CYCLES)-1.
  - BUSY: cnt decrements each cycle. When cnt==0, next state is DONE.
  - DONE→IDLE unconditionally after one cycle.
- md_start latency: md_start in cycle T gives BUSY in cycles T+1..T+N and md_done=1 in cycle T+N+1, where N is the op's cycle count.
- load_use = ex_is_load & (ex_rd≠0) & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)). Combinational.
- A load-use stall lasts exactly one cycle because the load advances to MEM and forwarding resolves the dependency.
- md_hazard = (state≠IDLE) & (id_md_op | id_reads_hilo) & ~id_flush.
  - MFHI/MFLO and new MD ops stall through BUSY and DONE.
  - They proceed in the cycle after DONE, when HI/LO is written.
- Stall = (load_use | md_hazard) & ~id_flush. A flushed ID instruction never stalls.
- pc_we = ifid_we = ~Stall.
- md_start = id_md_op & (state==IDLE) & ~Stall & ~id_flush. Combinational; it never asserts while Stall=1.
- Non-MD, non-HILO instructions proceed normally while state=BUSY or DONE.
- id_flush never aborts an MD op already in flight.
- md_busy = (state==BUSY | state==DONE). md_done = (state==DONE). Both are registered-state decodes, glitch-free.
- Simultaneous load_use and id_md_op in IDLE: Stall=1 and md_start=0. The op starts on the first cycle load_use clears.
- ex_rd==0 never causes a load-use stall.
- Counter is never loaded with an underflowed value because the parameters are ≥1. If cycle count is 1, BUSY lasts one cycle with cnt=0.

Test Plan:
1. Load-use: EX=LW with ex_rd=8; ID uses_rs=1, rs=8 → Stall=1, pc_we=0 for exactly 1 cycle. With rs=0 and ex_rd=0 → Stall=0.
2. MULT issue in IDLE at T → md_start=1 at T, md_busy=1 T+1..T+5, md_done=1 only at T+5. MFLO presented at T+1 → Stall=1 through T+5, Stall=0 at T+6.
3. DIV then immediate MULT: DIV start at T → MULT stalled T+1..T+33. md_done at T+33. MULT md_start at T+34.
4. Independent ADD during BUSY → Stall=0, pc_we=1 every cycle. md_done timing unchanged.
5. id_flush=1 with id_md_op=1 in IDLE → md_start=0, Stall=0, state stays IDLE. id_flush=1 during BUSY → md_done still at expected cycle.
6. rst_n=0 at cycle 10 of a DIV → next cycle state=IDLE, md_busy=0, md_done never asserts. A new MULT start is accepted right after reset.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Load-use and multiply/divide stall controller for the 5-stage pipeline.
// Sequences the MD unit through IDLE/BUSY/DONE and gates PC/IF-ID writes.
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_md_op,
  input  logic       id_md_div,
  input  logic       id_reads_hilo,
  input  logic       id_flush,
  input  logic [4:0] ex_rd,
  input  logic       ex_is_load,
  output logic       Stall,
  output logic       pc_we,
  output logic       ifid_we,
  output logic       md_start,
  output logic       md_busy,
  output logic       md_done
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;
  logic             md_hazard;
  logic             rs_hit;
  logic             rt_hit;

  assign rs_hit   = id_uses_rs & (id_rs == ex_rd);
  assign rt_hit   = id_uses_rt & (id_rt == ex_rd);
  assign load_use = ex_is_load & (ex_rd != 5'd0) & (rs_hit | rt_hit);

  // HI/LO readers and new MD ops wait until the in-flight op retires
  assign md_hazard = (state_q != IDLE)
                   & (id_md_op | id_reads_hilo)
                   & ~id_flush;

  assign Stall    = (load_use | md_hazard) & ~id_flush;
  assign pc_we    = ~Stall;
  assign ifid_we  = ~Stall;
  assign md_start = id_md_op & (state_q == IDLE)
                  & ~Stall & ~id_flush;
  assign md_busy  = (state_q == BUSY) | (state_q == DONE);
  assign md_done  = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (md_start) begin
          state_d = BUSY;
          cnt_d   = id_md_div ? DIV_LD : MULT_LD;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
